// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the framed serial transmitter and its future receiver.
// Pure declarations: no logic, no latency, no flow control.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int FRAME_BITS(input int data_w, input int parity_en, input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

  // Never returns less than 1 so a one-bit word still gets a legal index vector.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_framed_tx_if.sv
// Word-load / start-request bus and line-side status of the framed serial transmitter.
// master = the client feeding words, slave = the transmitter.
interface serial_framed_tx_if #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16
);
  logic [DATA_W-1:0] DataIn;
  logic              Sample;
  logic              StartTx;
  logic [DIV_W-1:0]  BaudDiv;
  logic              Dout;
  logic              TxBusy;
  logic              TxDone;
  logic              HoldFull;
  logic              Overrun;

  modport master (
    output DataIn, Sample, StartTx, BaudDiv,
    input  Dout, TxBusy, TxDone, HoldFull, Overrun
  );

  modport slave (
    input  DataIn, Sample, StartTx, BaudDiv,
    output Dout, TxBusy, TxDone, HoldFull, Overrun
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick is combinational on the last clock of each (divisor+1)-clock period.
// No flow control; restart holds the count at zero until released.
module baud_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = !restart && (cnt == divisor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/serial_framed_tx.sv
// Framed serial transmitter (start, data, optional parity, 1-2 stops) with a one-word holding buffer.
// Outputs registered, frame begins on the edge seeing StartTx with a full buffer; Sample into an unconsumed full buffer pulses Overrun.
module serial_framed_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_W      = 16,
  parameter int LSB_FIRST  = 0,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic               Clk,
  input logic               Reset_n,
  serial_framed_tx_if.slave bus
);
  localparam int               IDX_W     = clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] hold_q, shift_q, shift_d, shifted;
  logic              hold_full_q, overrun_q, parity_q;
  logic [DIV_W-1:0]  div_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              dout_q, dout_d, busy_q, busy_d, done_q, done_d;
  logic              consume, tick, next_bit;

  baud_tick_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .restart (state_q == IDLE),
    .divisor (div_q),
    .tick    (tick)
  );

  assign next_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_W-1];
  assign shifted  = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.StartTx && hold_full_q) consume = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          dout_d  = next_bit;
          shift_d = shifted;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q != LAST_IDX) begin
            dout_d  = next_bit;
            shift_d = shifted;
            idx_d   = idx_q + IDX_W'(1);
          end else if (PARITY_EN != 0) begin
            state_d = PARITY;
            dout_d  = parity_q;
          end else begin
            state_d = STOP;
            dout_d  = 1'b1;
            stop_d  = 1'b0;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          dout_d  = 1'b1;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q != STOP_LAST) begin
            stop_d = 1'b1;
          end else begin
            done_d = 1'b1;
            // Chained frames reload here so the next start bit follows with no idle gap.
            if (bus.StartTx && hold_full_q) begin
              consume = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              dout_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (consume) begin
      state_d = START;
      dout_d  = 1'b0;
      busy_d  = 1'b1;
      shift_d = hold_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      dout_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (consume) begin
        div_q    <= bus.BaudDiv;
        parity_q <= (^hold_q) ^ (PARITY_ODD != 0);
      end
    end
  end

  // A word consumed this edge frees the buffer, so a simultaneous Sample is accepted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (bus.Sample) begin
        if (!hold_full_q || consume) begin
          hold_q      <= bus.DataIn;
          hold_full_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (consume) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign bus.Dout     = dout_q;
  assign bus.TxBusy   = busy_q;
  assign bus.TxDone   = done_q;
  assign bus.HoldFull = hold_full_q;
  assign bus.Overrun  = overrun_q;
endmodule
